// File: rtl/timer_pkg.sv
// Shared types and default sizes for the programmable down-count timer.
package timer_pkg;
    localparam int TIMER_WIDTH = 32;
    localparam int TIMER_PRE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;
endpackage

// File: rtl/timer_prescaler.sv
// Reloadable prescaler: emits a one-cycle tick every pre+1 enabled cycles.
module timer_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             enable,
    input  logic [PRE_W-1:0] pre,
    output logic             tick
);
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

    // Restart takes priority so a re-armed timer always begins a fresh phase.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (restart)
            pre_cnt_d = pre;
        else if (enable)
            pre_cnt_d = (pre_cnt_q == '0) ? pre : pre_cnt_q - PRE_W'(1);
    end

    assign tick = enable && !restart && (pre_cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_cnt_q <= '0;
        else     pre_cnt_q <= pre_cnt_d;
    end
endmodule

// File: rtl/timer_ctrl.sv
// Down-count timer controller: FSM, live count and sticky irq/ovf flags;
// the tick rate comes from timer_prescaler.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH,
    parameter int PRE_W = TIMER_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_load,
    input  logic [PRE_W-1:0] cfg_pre,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_ack,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             irq,
    output logic             ovf
);
    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] load_reg_q, load_reg_d;
    logic [PRE_W-1:0] pre_reg_q, pre_reg_d;
    logic             periodic_reg_q, periodic_reg_d;
    logic             irq_q, irq_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    logic             expire;

    timer_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk     (clk),
        .rst     (rst),
        .restart (start && !stop),
        .enable  ((state_q == RUN) && !stop),
        .pre     (pre_reg_q),
        .tick    (tick)
    );

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        load_reg_d     = load_reg_q;
        pre_reg_d      = pre_reg_q;
        periodic_reg_d = periodic_reg_q;
        irq_d          = irq_q;
        ovf_d          = ovf_q;
        expire         = 1'b0;

        // A start in the same cycle still sees the old registers below.
        if (cfg_we && (state_q != RUN)) begin
            load_reg_d     = cfg_load;
            pre_reg_d      = cfg_pre;
            periodic_reg_d = cfg_periodic;
        end

        if (irq_ack) begin
            irq_d = 1'b0;
            ovf_d = 1'b0;
        end

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            count_d = load_reg_q;
            if (load_reg_q == '0) begin
                expire  = 1'b1;
                state_d = DONE;
            end else begin
                state_d = RUN;
            end
        end else if ((state_q == RUN) && tick) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
                expire = 1'b1;
                if (periodic_reg_q) begin
                    count_d = load_reg_q;
                end else begin
                    count_d = '0;
                    state_d = DONE;
                end
            end
        end

        // Set beats clear for irq; a simultaneous ack still clears ovf.
        if (expire) begin
            irq_d = 1'b1;
            if (irq_q && !irq_ack) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            load_reg_q     <= '0;
            pre_reg_q      <= '0;
            periodic_reg_q <= 1'b0;
            irq_q          <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            load_reg_q     <= load_reg_d;
            pre_reg_q      <= pre_reg_d;
            periodic_reg_q <= periodic_reg_d;
            irq_q          <= irq_d;
            ovf_q          <= ovf_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign count = count_q;
    assign irq   = irq_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scoreboard bench for timer_ctrl: expectations are queued as stimulus
// is driven and compared once the DUT has responded.
module tb_timer_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [31:0] cfg_load;
    logic [7:0]  cfg_pre;
    logic        cfg_periodic;
    logic        start;
    logic        stop;
    logic        irq_ack;
    logic        busy;
    logic [31:0] count;
    logic        irq;
    logic        ovf;

    typedef struct {
        string       tag;
        logic        busy;
        logic        irq;
        logic        ovf;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];
    int   vec  = 0;
    int   miss = 0;

    timer_ctrl #(.WIDTH(32), .PRE_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_load     (cfg_load),
        .cfg_pre      (cfg_pre),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
        .irq_ack      (irq_ack),
        .busy         (busy),
        .count        (count),
        .irq          (irq),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic b, input logic i,
                            input logic o, input logic [31:0] c);
        sb.push_back('{tag, b, i, o, c});
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        vec++;
        assert ({busy, irq, ovf, count} === {e.busy, e.irq, e.ovf, e.count})
        else begin
            miss++;
            $error("FAIL %s: got busy=%0b irq=%0b ovf=%0b count=%0d, want busy=%0b irq=%0b ovf=%0b count=%0d",
                   e.tag, busy, irq, ovf, count, e.busy, e.irq, e.ovf, e.count);
        end
    endtask

    // Queue the expectation for the edge that samples the current inputs.
    task automatic step(input string tag, input logic b, input logic i,
                        input logic o, input logic [31:0] c);
        push_exp(tag, b, i, o, c);
        cyc();
        check_out();
    endtask

    task automatic cfg(input logic [31:0] n, input logic [7:0] p, input logic per);
        cfg_we = 1'b1; cfg_load = n; cfg_pre = p; cfg_periodic = per;
        cyc();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_load = '0; cfg_pre = '0; cfg_periodic = 1'b0;
        start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
        repeat (2) cyc();
        push_exp("reset", 0, 0, 0, 0);
        check_out();
        rst = 1'b0;
        cyc();

        // one-shot N=5 P=0
        cfg(5, 0, 0);
        start = 1'b1;
        step("os_load", 1, 0, 0, 5);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step($sformatf("os_cnt%0d", k), 1, 0, 0, 32'(5 - k));
        step("os_expire", 0, 1, 0, 0);
        step("os_done_hold", 0, 1, 0, 0);
        irq_ack = 1'b1;
        step("os_ack", 0, 0, 0, 0);
        irq_ack = 1'b0;

        // periodic N=3 P=1: expiries every 6 cycles
        cfg(3, 1, 1);
        start = 1'b1;
        step("per_load", 1, 0, 0, 3);
        start = 1'b0;
        repeat (4) cyc();
        step("per_e5", 1, 0, 0, 1);
        step("per_exp1", 1, 1, 0, 3);
        repeat (4) cyc();
        step("per_e11", 1, 1, 0, 1);
        step("per_exp2_ovf", 1, 1, 1, 3);
        irq_ack = 1'b1;
        step("per_ack", 1, 0, 0, 3);
        irq_ack = 1'b0;
        repeat (4) cyc();
        step("per_exp3", 1, 1, 0, 3);
        repeat (5) cyc();
        irq_ack = 1'b1;
        step("ack_collide", 1, 1, 0, 3);
        irq_ack = 1'b0;
        stop = 1'b1;
        step("per_stop", 0, 1, 0, 3);
        stop = 1'b0;
        irq_ack = 1'b1;
        step("per_clr", 0, 0, 0, 3);
        irq_ack = 1'b0;

        // stop mid-count, restart, start+stop collision
        cfg(5, 0, 0);
        start = 1'b1;
        step("ctl_load", 1, 0, 0, 5);
        start = 1'b0;
        repeat (2) cyc();
        step("ctl_cnt2", 1, 0, 0, 2);
        stop = 1'b1;
        step("ctl_stop", 0, 0, 0, 2);
        stop = 1'b0;
        step("ctl_hold", 0, 0, 0, 2);
        start = 1'b1;
        step("ctl_reload", 1, 0, 0, 5);
        stop = 1'b1;
        step("ctl_startstop", 0, 0, 0, 5);
        start = 1'b0; stop = 1'b0;

        // cfg_we while running is dropped
        start = 1'b1;
        step("cfg_run_load", 1, 0, 0, 5);
        start = 1'b0;
        cfg_we = 1'b1; cfg_load = 9;
        step("cfg_run_ignored", 1, 0, 0, 4);
        cfg_we = 1'b0;
        stop = 1'b1;
        step("cfg_stop", 0, 0, 0, 4);
        stop = 1'b0;
        start = 1'b1;
        step("cfg_old_n", 1, 0, 0, 5);
        start = 1'b0;
        stop = 1'b1;
        step("cfg_stop2", 0, 0, 0, 5);
        stop = 1'b0;

        // cfg_we with start: start uses old N, new N is latched
        cfg_we = 1'b1; cfg_load = 7; start = 1'b1;
        step("cfg_start_old", 1, 0, 0, 5);
        cfg_we = 1'b0; start = 1'b0;
        stop = 1'b1;
        step("cfg_stop3", 0, 0, 0, 5);
        stop = 1'b0;
        start = 1'b1;
        step("cfg_new_n", 1, 0, 0, 7);
        start = 1'b0;
        stop = 1'b1;
        step("n0_prestop", 0, 0, 0, 7);
        stop = 1'b0;

        // N=0: immediate expiry into DONE
        cfg(0, 0, 0);
        start = 1'b1;
        step("n0_done", 0, 1, 0, 0);
        start = 1'b0;
        step("n0_hold", 0, 1, 0, 0);
        irq_ack = 1'b1;
        step("n0_ack", 0, 0, 0, 0);
        irq_ack = 1'b0;

        // N=1 P=255: expiry 256 cycles after start
        cfg(1, 255, 0);
        start = 1'b1;
        step("p255_load", 1, 0, 0, 1);
        start = 1'b0;
        repeat (254) cyc();
        step("p255_e255", 1, 0, 0, 1);
        step("p255_exp", 0, 1, 0, 0);
        irq_ack = 1'b1;
        step("p255_ack", 0, 0, 0, 0);
        irq_ack = 1'b0;

        // async reset in the middle of a periodic run with irq set
        cfg(2, 0, 1);
        start = 1'b1;
        step("rr_load", 1, 0, 0, 2);
        start = 1'b0;
        step("rr_e1", 1, 0, 0, 1);
        step("rr_exp", 1, 1, 0, 2);
        step("rr_e3", 1, 1, 0, 1);
        #2 rst = 1'b1;
        #1;
        push_exp("rr_async", 0, 0, 0, 0);
        check_out();
        rst = 1'b0;
        step("rr_after", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
